// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and HI/LO sequencer state encodings shared across the core.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

  // Iteration counter load value: 32 steps run as 31 down to 0 inclusive.
  localparam logic [4:0] HL_CNT_LOAD = 5'd31;

  // Full CPU opcode space; the HI/LO unit only acts on DIV/DIVU/MTHI/MTLO/MULT/MULTU.
  typedef enum logic [6:0] {
    OP_ADD   = 7'd0,
    OP_SUB   = 7'd1,
    OP_AND   = 7'd2,
    OP_OR    = 7'd3,
    OP_XOR   = 7'd4,
    OP_SLL   = 7'd5,
    OP_SRL   = 7'd6,
    OP_DIV   = 7'd7,
    OP_DIVU  = 7'd8,
    OP_MFHI  = 7'd9,
    OP_MFLO  = 7'd10,
    OP_MTHI  = 7'd11,
    OP_MTLO  = 7'd12,
    OP_MULT  = 7'd13,
    OP_MULTU = 7'd14,
    OP_LW    = 7'd15,
    OP_SW    = 7'd16
  } opcode_t;

  // HI/LO sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_ITER = 2'd1,
    ST_DIV_ITER = 2'd2,
    ST_FINISH   = 2'd3
  } hl_state_t;

  // Signed multiply/divide work on magnitudes and fix the sign at the end.
  function automatic logic op_is_signed(input logic [6:0] op_v);
    return (op_v == OP_MULT) || (op_v == OP_DIV);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: unsigned restoring divider datapath, one quotient bit per step.
// Latency: result valid after 32 step_i cycles following load_i; no internal sequencing.
// Backpressure: none; the caller owns the step count and ignores outputs until done.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            qbit;

  // One restoring step: shift the next dividend bit into the partial remainder, try to subtract.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    // A carry out of the shift means the trial value already exceeds any XLEN-bit divisor.
    qbit    = shifted[XLEN] | ~diff[XLEN];
    rem_d   = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], qbit};
  end

  // Remainder/quotient registers: load clears the remainder, each step retires one quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/hi_lo_sequencer.sv
// hi_lo_sequencer: HI/LO unit with iterative shift-add multiply and restoring divide.
// Latency: MULT/DIV 33 cycles from accept to HI/LO update, done one cycle after; MTHI/MTLO write at accept.
// Backpressure: starts while busy are dropped (not queued); stall = mf_req & busy. Option: HI_LO_FAST_MULT_EN.
module hi_lo_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mf_req,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import cpu_pkg::*;

  hl_state_t         state_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, rneg_q, dbz_q, is_div_q;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, done_q;

  logic              sgn_op;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              neg_d, rneg_d;
  logic              div_load, div_step_en;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;

  // Operand conditioning at accept: magnitudes for signed ops and the sign-fixup flags.
  always_comb begin
    sgn_op      = op_is_signed(op);
    a_mag       = (sgn_op && a[XLEN-1]) ? -a : a;
    b_mag       = (sgn_op && b[XLEN-1]) ? -b : b;
    neg_d       = sgn_op & (a[XLEN-1] ^ b[XLEN-1]);
    rneg_d      = sgn_op & a[XLEN-1];
    div_load    = (state_q == ST_IDLE) && start && ((op == OP_DIV) || (op == OP_DIVU));
    div_step_en = (state_q == ST_DIV_ITER);
  end

`ifdef HI_LO_FAST_MULT_EN
  logic [2*XLEN-1:0] fast_prod;

  // Single-cycle product; sign-extending to full width makes the low 2*XLEN bits exact.
  always_comb begin
    if (sgn_op) begin
      fast_prod = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    end else begin
      fast_prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    end
  end
`endif

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {mul_sum, prod_q[XLEN-1:1]};
  end

  // Sign fixup and HI/LO selection applied in FINISH; divide-by-zero quotient is all ones.
  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = dbz_q ? '1 : (neg_q ? -quo : quo);
    rem_fix  = rneg_q ? -rem : rem;
    hi_d     = is_div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    lo_d     = is_div_q ? quo_fix : prod_fix[XLEN-1:0];
  end

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .step_i     (div_step_en),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // Control FSM with registered busy/done and HI/LO; done defaults low so it is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
`ifdef HI_LO_FAST_MULT_EN
                hi_q   <= fast_prod[2*XLEN-1:XLEN];
                lo_q   <= fast_prod[XLEN-1:0];
                done_q <= 1'b1;
`else
                mcand_q  <= a_mag;
                prod_q   <= {{XLEN{1'b0}}, b_mag};
                neg_q    <= neg_d;
                is_div_q <= 1'b0;
                cnt_q    <= HL_CNT_LOAD;
                busy_q   <= 1'b1;
                state_q  <= ST_MUL_ITER;
`endif
              end
              OP_DIV, OP_DIVU: begin
                neg_q    <= neg_d;
                rneg_q   <= rneg_d;
                dbz_q    <= (b == '0);
                is_div_q <= 1'b1;
                cnt_q    <= HL_CNT_LOAD;
                busy_q   <= 1'b1;
                state_q  <= ST_DIV_ITER;
              end
              OP_MTHI: begin
                hi_q   <= a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL_ITER: begin
          prod_q <= prod_d;
          if (cnt_q == 5'd0) begin
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_DIV_ITER: begin
          if (cnt_q == 5'd0) begin
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_FINISH: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = mf_req & busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/hi_lo_sequencer.md
HI_LO_SEQUENCER -- requirements
Module: hi_lo_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to issue op; accepted only when busy=0.
REQ-005 SHALL have port op  input  7  opcode_t: DIV=7, DIVU=8, MTHI=11, MTLO=12, MULT=13, MULTU=14.
REQ-006 SHALL have ports a, b  input  32 each  rs / rt operands, sampled on the accept edge.
REQ-007 SHALL have port mf_req  input  1  the core is executing MFHI/MFLO this cycle.
REQ-008 SHALL have port busy  output  1  multiply/divide in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: HI/LO just updated.
REQ-010 SHALL have port stall  output  1  equal to mf_req & busy.
REQ-011 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, MUL_ITER, DIV_ITER and FINISH.
REQ-013 In IDLE, start with MULT/MULTU SHALL latch operands, load a 5-bit counter with 31 and go to MUL_ITER; DIV/DIVU SHALL go to DIV_ITER.
REQ-014 In IDLE, start with MTHI/MTLO SHALL write a into hi/lo at that edge, pulse done next cycle, and keep busy=0.
REQ-015 In IDLE, start with any other op SHALL be ignored: no state change, no done.
REQ-016 MUL_ITER SHALL perform one shift-add step per cycle on operand magnitudes for 32 cycles, then go to FINISH.
REQ-017 DIV_ITER SHALL perform one restoring-division step per cycle for 32 cycles, then go to FINISH.
REQ-018 FINISH SHALL apply sign fixup, write hi/lo, assert done for exactly that cycle and return to IDLE.
REQ-019 Latency for a start accepted at edge E0: hi/lo update at E33; done high in the cycle ending at E34; busy high from E0 to E33.
REQ-020 Signed ops SHALL use magnitudes; product/quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-021 MULT/MULTU SHALL give hi = product[63:32] and lo = product[31:0].
REQ-022 Divide by zero (any sign) SHALL give lo = 32'hFFFF_FFFF and hi = a, with full latency.
REQ-023 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000 and hi = 0.
REQ-024 start while busy=1 SHALL be ignored; the op in flight SHALL continue unchanged.
REQ-025 start in the FINISH cycle SHALL be ignored; start in the following cycle SHALL be accepted.
REQ-026 hi/lo SHALL hold their previous values throughout an operation and change only at the FINISH edge.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, stall=0, regardless of clk.
REQ-028 Reset during MUL_ITER/DIV_ITER SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first edge.

Configuration
REQ-029 With HI_LO_FAST_MULT_EN defined, MULT/MULTU SHALL be single-cycle: hi/lo written at E0, done high in the cycle ending at E1, busy never asserted.
REQ-030 With HI_LO_FAST_MULT_EN undefined, REQ-016 and REQ-019 apply; division behaviour SHALL be identical in both builds.

Structure
REQ-031 opcode_t (full CPU opcode enum, values as in REQ-005) and the state enum SHALL live in the shared package cpu_pkg.
REQ-032 The divide datapath SHALL be a sub-module div_step, containing the remainder/quotient registers and one restoring step per cycle; the multiply datapath and FSM SHALL stay in hi_lo_sequencer.

Verification
REQ-033 MULTU a=b=32'hFFFF_FFFF -> after 33 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001, one done pulse.
REQ-034 MULT a=32'hFFFF_FFFD (-3), b=5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-035 DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-036 mf_req=1 held from cycle 5 of a DIVU -> stall=1 until busy falls; start with MTLO mid-op -> ignored, lo unchanged.
REQ-037 rst_n pulsed low at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done.
REQ-038 MTHI a=32'h1234_5678 from idle -> hi=32'h1234_5678 next cycle, done for one cycle, busy stays 0.
